// File: rtl/pcie_dll_pkg.sv
// Shared data-link-layer types and sequence-number helpers (12-bit, modulo 4096).
package pcie_dll_pkg;
  localparam int SEQ_WIDTH = 12;
  localparam int SEQ_MOD   = 1 << SEQ_WIDTH;
  // Default replay timeout for Gen1/Gen2 x1 links, in clk cycles.
  localparam int DEF_REPLAY_TIMER_LIMIT = 711;

  typedef logic [SEQ_WIDTH-1:0] seq_t;
  typedef enum logic {IDLE, REPLAY} replay_state_e;

  function automatic seq_t seq_diff(input seq_t a, input seq_t b);
    return seq_t'((int'(a) - int'(b) + SEQ_MOD) % SEQ_MOD);
  endfunction

  // An AckNak_Seq_Num is acceptable if it lies no further past the
  // acknowledged point than the number of outstanding TLPs.
  function automatic logic seq_in_window(input seq_t seq, input seq_t base, input seq_t span);
    return seq_diff(seq, base) <= span;
  endfunction
endpackage

// File: rtl/dll_replay_timer.sv
// Free-running timeout counter with enable/clear; restarts at 0 after expiring.
module dll_replay_timer #(
  parameter int LIMIT = 711,
  localparam int W    = $clog2(LIMIT + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en,
  input  logic clr,
  output logic expire
);
  logic [W-1:0] count;

  assign expire = (count == W'(LIMIT));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                count <= '0;
    else if (clr || expire)   count <= '0;
    else if (en)              count <= count + W'(1);
  end
endmodule

// File: rtl/dllp_replay_ctrl.sv
// Transmit-side replay controller: sequence tracking, ACK/NAK purge, replay timer/REPLAY_NUM.
// Optional replay/NAK statistics counters under DLLP_REPLAY_STATS_EN.
module dllp_replay_ctrl
  import pcie_dll_pkg::*;
#(
  parameter int RETRY_DEPTH        = 256,
  parameter int INDEX_WIDTH        = 8,
  parameter int REPLAY_TIMER_LIMIT = DEF_REPLAY_TIMER_LIMIT,
  parameter int REPLAY_NUM_MAX     = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   tlp_sent_i,
  input  logic [SEQ_WIDTH-1:0]   tlp_seq_i,
  input  logic                   ack_valid_i,
  input  logic                   ack_is_nak_i,
  input  logic [SEQ_WIDTH-1:0]   ack_seq_i,
  input  logic                   retry_done_i,
  output logic                   retry_available_o,
  output logic [INDEX_WIDTH-1:0] retry_index_o,
  output logic [SEQ_WIDTH-1:0]   acked_seq_o,
  output logic [INDEX_WIDTH:0]   outstanding_o,
  output logic                   tx_full_o,
  output logic                   retrain_req_o,
`ifdef DLLP_REPLAY_STATS_EN
  output logic [15:0]            replay_cnt_o,
  output logic [15:0]            nak_cnt_o,
`endif
  output logic                   seq_err_o
);
  localparam int RN_W = $clog2(REPLAY_NUM_MAX + 2);

  replay_state_e   state, state_nxt;
  seq_t            acked_seq, next_seq, acked_nxt, next_nxt, outs, outs_nxt;
  logic [RN_W-1:0] replay_num, rn_base, replay_num_nxt;
  logic            pending, pending_nxt, retrain_nxt, start_replay;
  logic            tlp_ok, ack_ok, progress, nak_ok, seq_err_nxt;
  logic            tmr_en, tmr_clr, tmr_expire, timeout;

  assign outs      = seq_diff(next_seq, acked_seq + seq_t'(1));
  assign tx_full_o = (outs == seq_t'(RETRY_DEPTH));

  assign tlp_ok   = tlp_sent_i && (tlp_seq_i == next_seq) && !tx_full_o;
  // Window check uses the pre-update outstanding count.
  assign ack_ok   = ack_valid_i && seq_in_window(ack_seq_i, acked_seq, outs);
  assign progress = ack_ok && (ack_seq_i != acked_seq);
  assign nak_ok   = ack_ok && ack_is_nak_i;
  assign seq_err_nxt = (tlp_sent_i && !tlp_ok) || (ack_valid_i && !ack_ok);

  assign acked_nxt = progress ? ack_seq_i : acked_seq;
  assign next_nxt  = tlp_ok ? next_seq + seq_t'(1) : next_seq;
  assign outs_nxt  = seq_diff(next_nxt, acked_nxt + seq_t'(1));

  assign tmr_en  = (outs != '0) && (state == IDLE);
  assign tmr_clr = progress || (outs == '0) || ((state == REPLAY) && retry_done_i);
  assign timeout = tmr_expire && !progress;

  dll_replay_timer #(.LIMIT(REPLAY_TIMER_LIMIT)) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en     (tmr_en),
    .clr    (tmr_clr),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    rn_base        = progress ? '0 : replay_num;
    replay_num_nxt = rn_base;
    pending_nxt    = pending;
    retrain_nxt    = 1'b0;
    start_replay   = 1'b0;
    case (state)
      IDLE: begin
        if (nak_ok || timeout || pending) begin
          pending_nxt = 1'b0;
          // Nothing left to resend: the request is simply consumed.
          if (outs_nxt != '0) begin
            start_replay = 1'b1;
            state_nxt    = REPLAY;
            if (rn_base == RN_W'(REPLAY_NUM_MAX)) begin
              replay_num_nxt = '0;
              retrain_nxt    = 1'b1;
            end else begin
              replay_num_nxt = rn_base + RN_W'(1);
            end
          end
        end
      end
      REPLAY: begin
        if (nak_ok || timeout) pending_nxt = 1'b1;
        if (retry_done_i)      state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acked_seq     <= '1;
      next_seq      <= '0;
      replay_num    <= '0;
      pending       <= 1'b0;
      retry_index_o <= '0;
      retrain_req_o <= 1'b0;
      seq_err_o     <= 1'b0;
    end else begin
      acked_seq     <= acked_nxt;
      next_seq      <= next_nxt;
      replay_num    <= replay_num_nxt;
      pending       <= pending_nxt;
      retrain_req_o <= retrain_nxt;
      seq_err_o     <= seq_err_nxt;
      // Frozen during replay so tlp2dllp reads out from a stable start slot.
      if (state != REPLAY)
        retry_index_o <= INDEX_WIDTH'(acked_nxt + seq_t'(1));
    end
  end

  assign retry_available_o = (state == REPLAY);
  assign acked_seq_o       = acked_seq;
  assign outstanding_o     = outs[INDEX_WIDTH:0];

`ifdef DLLP_REPLAY_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      replay_cnt_o <= '0;
      nak_cnt_o    <= '0;
    end else begin
      if (start_replay && replay_cnt_o != 16'hFFFF) replay_cnt_o <= replay_cnt_o + 16'd1;
      if (nak_ok && nak_cnt_o != 16'hFFFF)          nak_cnt_o    <= nak_cnt_o + 16'd1;
    end
  end
`endif
endmodule
